pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised successor to the single-cycle next-PC selector: holds the architectural fetch PC and generates the next PC every cycle.
- Adds a fetch handshake, stall hold, EX-stage redirect capture with a pending buffer, a trap vector path, a flush pulse, and misalignment detection.
- Sits between the IF stage (instruction memory request) and the EX stage (branch/jump resolution).

Parameters:
- XLEN, 32, PC/operand width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset (XLEN bits).
- INC, 4, sequential PC increment.
- BTB_ENTRIES, 8, BTB depth; power of 2, ≥2; used only with PC_GEN_BTB_EN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- if_ready  in  1  instruction memory accepts pc this cycle
- stall  in  1  hazard hold from ID; holds PC
- npc_op  in  3  EX redirect kind: 3'b000 PLUS4, 3'b001 BRANCH, 3'b010 JUMP, 3'b100 JALR
- ex_pc  in  XLEN  PC of instruction in EX
- imm  in  XLEN  sign-extended immediate from EX
- aluout  in  XLEN  JALR target from ALU
- trap_req  in  1  trap/exception request
- trap_vec  in  XLEN  trap handler address
- pc  out  XLEN  current fetch PC
- pc_valid  out  1  pc is a valid fetch request
- flush  out  1  kill IF/ID and ID/EX contents this cycle
- misalign  out  1  redirect target has bits [1:0] != 0
- pred_taken  out  1  BTB hit used for this pc (0 when feature off)

Behaviour:
- Reset (async, during rst): pc=RESET_PC, pc_valid=0, state=BOOT, pending cleared, BTB valid bits cleared. flush, misalign and pred_taken are 0 throughout rst.
- States:
  - BOOT: first clk edge after rst deasserts → RUN, pc_valid=1. pc is unchanged.
  - RUN: normal operation.
  - PEND: a redirect is buffered, waiting for if_ready.
- Redirect sources:
  - redir_ex = (npc_op != 3'b000).
  - Targets:
    - BRANCH/JUMP: ex_pc+imm.
    - JALR: aluout with bit0 cleared.
    - Trap: trap_vec.
  - Any other npc_op code is treated as PLUS4, i.e. no redirect.
  - Priority: trap_req > redir_ex > pending > BTB prediction > pc+INC.
- flush: combinational, 1 in any cycle where trap_req or redir_ex is asserted, in state RUN or PEND.
- misalign: combinational, 1 when the selected new redirect target[1:0] != 0. The redirect is still taken; trap handling is external.
- fire = pc_valid & if_ready & ~stall. At the clock edge:
  - New redirect with if_ready=1: pc←target, state RUN, pending cleared. This applies even when stall=1, since the stalled instructions are flushed.
  - New redirect with if_ready=0: pending←target, state PEND, pc unchanged.
  - A newer redirect in PEND overwrites pending.
  - PEND, no new redirect, if_ready=1: pc←pending, state RUN.
  - RUN, no redirect, fire: pc←pc+INC, or the BTB target on a hit.
  - Otherwise pc is held.
- Arithmetic is modulo 2^XLEN; pc+INC wraps from all-ones-minus-3 to 0 silently.
- Latency: redirect presented in cycle N → new pc visible in cycle N+1 when if_ready=1.

Optional Feature:
- Macro PC_GEN_BTB_EN.
- Defined:
  - Direct-mapped BTB with BTB_ENTRIES entries: valid, tag = pc[XLEN-1:2+log2(BTB_ENTRIES)], target.
  - Index = pc[1+log2(BTB_ENTRIES):2].
  - Lookup is on the current pc. On a hit in RUN with fire, next pc = stored target and pred_taken=1.
  - Update on a BRANCH/JUMP redirect (not JALR, not trap): entry at ex_pc's index is written valid with ex_pc's tag and the target, at the same edge as the redirect.
  - Extra input btb_inv (1 bit): invalidates the entry indexed by ex_pc. It is not a flush; EX issues a separate redirect.
  - Same-cycle update and lookup of the same index: lookup sees the old contents.
- Undefined: no BTB storage, no btb_inv port, pred_taken tied 0.

Test Plan:
- Reset with RESET_PC=32'h100, then release, if_ready=1, stall=0 → pc_valid=0 for one cycle; then pc sequence 0x100, 0x104, 0x108.
- stall=1 for 3 cycles at pc=0x108 → pc stays 0x108, flush=0; release → 0x10C.
- npc_op=BRANCH, ex_pc=0x104, imm=0x20, stall=1 → flush=1 the same cycle; next pc=0x124.
- npc_op=JALR, aluout=0x203, if_ready=0 for 2 cycles → flush=1, misalign=1, state PEND, pc held; when if_ready rises → pc=0x202.
- trap_req=1, trap_vec=0x800, simultaneous npc_op=JUMP → pc=0x800. Also assert rst mid-PEND → pc=RESET_PC immediately and the pending redirect is lost.
- (PC_GEN_BTB_EN) JUMP at ex_pc=0x110 to 0x300; later fetch reaches 0x110 → pred_taken=1 and next pc=0x300. btb_inv at ex_pc=0x110 → the next fetch of 0x110 is followed by 0x114.

Source files
------------

// File: rtl/pc_gen_if.sv
// Fetch/redirect bundle between pc_gen, the IF stage and the EX stage.
// btb_inv is present only when PC_GEN_BTB_EN is defined.
interface pc_gen_if #(
   parameter int XLEN = 32
);
`ifdef PC_GEN_BTB_EN
   logic            btb_inv;
`endif
   logic            if_ready;
   logic            stall;
   logic [2:0]      npc_op;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] aluout;
   logic            trap_req;
   logic [XLEN-1:0] trap_vec;
   logic [XLEN-1:0] pc;
   logic            pc_valid;
   logic            flush;
   logic            misalign;
   logic            pred_taken;
   logic [1:0]      fsm_state;

   // Handshake: a fetch of pc is accepted on a rising clk edge when
   // pc_valid & if_ready & ~stall; a redirect needs only if_ready.
   modport master (
`ifdef PC_GEN_BTB_EN
      input  btb_inv,
`endif
      input  if_ready, stall, npc_op, ex_pc, imm, aluout, trap_req, trap_vec,
      output pc, pc_valid, flush, misalign, pred_taken, fsm_state
   );

   modport slave (
`ifdef PC_GEN_BTB_EN
      output btb_inv,
`endif
      output if_ready, stall, npc_op, ex_pc, imm, aluout, trap_req, trap_vec,
      input  pc, pc_valid, flush, misalign, pred_taken, fsm_state
   );
endinterface

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential fetch, stall hold, trap/EX redirects with a
// pending buffer, flush/misalign flags. Optional BTB under PC_GEN_BTB_EN.
module pc_gen #(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter int              INC         = 4,
   parameter int              BTB_ENTRIES = 8
) (
   input logic      clk,
   input logic      rst,
   pc_gen_if.master bus
);
   typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, PEND = 2'd2} state_t;

   state_t          state, state_nx;
   logic [XLEN-1:0] pc_q, pc_nx, pend_q, pend_nx;
   logic [XLEN-1:0] target, seq_pc, btb_target;
   logic            is_br_jmp, is_jalr, active, new_redir, fire;
   logic            btb_hit, use_btb;

   always_comb begin
      is_br_jmp = (bus.npc_op == 3'b001) || (bus.npc_op == 3'b010);
      is_jalr   = (bus.npc_op == 3'b100);
      active    = (state != BOOT);
      // Unlisted npc_op codes fall through as PLUS4.
      new_redir = active && (bus.trap_req || is_br_jmp || is_jalr);
      if (bus.trap_req)
         target = bus.trap_vec;
      else if (is_jalr)
         target = {bus.aluout[XLEN-1:1], 1'b0};
      else
         target = bus.ex_pc + bus.imm;
      fire    = active && bus.if_ready && !bus.stall;
      use_btb = (state == RUN) && !new_redir && fire && btb_hit;
      seq_pc  = use_btb ? btb_target : pc_q + XLEN'(INC);
   end

   assign bus.pc         = pc_q;
   assign bus.pc_valid   = active;
   assign bus.flush      = new_redir;
   assign bus.misalign   = new_redir && (target[1:0] != 2'b00);
   assign bus.pred_taken = use_btb;
   assign bus.fsm_state  = state;

   always_comb begin
      state_nx = state;
      pc_nx    = pc_q;
      pend_nx  = pend_q;
      case (state)
         BOOT: state_nx = RUN;
         RUN: begin
            if (new_redir) begin
               if (bus.if_ready) begin
                  pc_nx = target;
               end else begin
                  pend_nx  = target;
                  state_nx = PEND;
               end
            end else if (fire) begin
               pc_nx = seq_pc;
            end
         end
         PEND: begin
            // A fresh redirect supersedes whatever is buffered.
            if (new_redir) begin
               if (bus.if_ready) begin
                  pc_nx    = target;
                  pend_nx  = '0;
                  state_nx = RUN;
               end else begin
                  pend_nx = target;
               end
            end else if (bus.if_ready) begin
               pc_nx    = pend_q;
               pend_nx  = '0;
               state_nx = RUN;
            end
         end
         default: state_nx = BOOT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= BOOT;
         pc_q   <= RESET_PC;
         pend_q <= '0;
      end else begin
         state  <= state_nx;
         pc_q   <= pc_nx;
         pend_q <= pend_nx;
      end
   end

`ifdef PC_GEN_BTB_EN
   localparam int IW = $clog2(BTB_ENTRIES);
   localparam int TW = XLEN - 2 - IW;

   logic [BTB_ENTRIES-1:0] btb_valid;
   logic [TW-1:0]          btb_tag [BTB_ENTRIES];
   logic [XLEN-1:0]        btb_tgt [BTB_ENTRIES];
   logic [IW-1:0]          lk_idx, ex_idx;
   logic                   btb_wr;

   always_comb begin
      lk_idx     = pc_q[IW+1:2];
      ex_idx     = bus.ex_pc[IW+1:2];
      btb_hit    = btb_valid[lk_idx] && (btb_tag[lk_idx] == pc_q[XLEN-1:IW+2]);
      btb_target = btb_tgt[lk_idx];
      btb_wr     = active && !bus.trap_req && is_br_jmp;
   end

   // Registered write: a same-cycle lookup of this index sees old contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         btb_valid <= '0;
      else if (bus.btb_inv)
         btb_valid[ex_idx] <= 1'b0;
      else if (btb_wr)
         btb_valid[ex_idx] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (btb_wr) begin
         btb_tag[ex_idx] <= bus.ex_pc[XLEN-1:IW+2];
         btb_tgt[ex_idx] <= target;
      end
   end
`else
   assign btb_hit    = 1'b0;
   assign btb_target = '0;
`endif
endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// compared against a behavioural next-PC model.
module tb_pc_gen;
   localparam logic [31:0] RST_PC = 32'h100;
   localparam int          BTB_N  = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   pc_gen_if #(.XLEN(32)) bus ();

   pc_gen #(.XLEN(32), .RESET_PC(RST_PC), .INC(4), .BTB_ENTRIES(BTB_N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Behavioural model: fetch PC, boot flag, at most one buffered target.
   bit          m_booted;
   logic [31:0] m_pc;
   logic [31:0] pend_q[$];
`ifdef PC_GEN_BTB_EN
   logic [31:0] btb_src[int];
   logic [31:0] btb_dst[int];
`endif

   function automatic bit op_is_redirect();
      return (bus.npc_op == 3'b001) || (bus.npc_op == 3'b010) || (bus.npc_op == 3'b100);
   endfunction

   function automatic bit m_redir();
      return m_booted && (bus.trap_req || op_is_redirect());
   endfunction

   function automatic logic [31:0] m_target();
      if (bus.trap_req) return bus.trap_vec;
      if (bus.npc_op == 3'b100) return bus.aluout & 32'hFFFF_FFFE;
      return bus.ex_pc + bus.imm;
   endfunction

   function automatic bit m_hit();
`ifdef PC_GEN_BTB_EN
      int idx;
      idx = int'((m_pc >> 2) % BTB_N);
      return btb_src.exists(idx) && (btb_src[idx][31:2] == m_pc[31:2]);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] m_hit_target();
`ifdef PC_GEN_BTB_EN
      return btb_dst[int'((m_pc >> 2) % BTB_N)];
`else
      return 32'h0;
`endif
   endfunction

   function automatic bit m_pred();
      return m_booted && (pend_q.size() == 0) && !m_redir() && bus.if_ready && !bus.stall && m_hit();
   endfunction

   task automatic model_reset();
      m_booted = 1'b0;
      m_pc     = RST_PC;
      pend_q.delete();
`ifdef PC_GEN_BTB_EN
      btb_src.delete();
      btb_dst.delete();
`endif
   endtask

   // One clock: compute the model's next state from the driven inputs,
   // take the edge, then settle 1 time unit past it.
   task automatic tick();
      logic [31:0] npc;
      logic [31:0] tgt;
      bit          redir;
`ifdef PC_GEN_BTB_EN
      bit          upd, inv;
      int          eidx;
      logic [31:0] epc;
`endif
      npc   = m_pc;
      tgt   = m_target();
      redir = m_redir();
`ifdef PC_GEN_BTB_EN
      upd  = m_booted && !bus.trap_req && ((bus.npc_op == 3'b001) || (bus.npc_op == 3'b010));
      inv  = bus.btb_inv;
      epc  = bus.ex_pc;
      eidx = int'((epc >> 2) % BTB_N);
`endif
      if (!m_booted) begin
         npc = m_pc;
      end else if (redir) begin
         pend_q.delete();
         if (bus.if_ready) npc = tgt;
         else pend_q.push_back(tgt);
      end else if (pend_q.size() != 0) begin
         if (bus.if_ready) npc = pend_q.pop_front();
      end else if (bus.if_ready && !bus.stall) begin
         npc = m_hit() ? m_hit_target() : m_pc + 32'd4;
      end
      @(posedge clk);
      m_pc     = npc;
      m_booted = 1'b1;
`ifdef PC_GEN_BTB_EN
      if (inv) begin
         btb_src.delete(eidx);
         btb_dst.delete(eidx);
      end else if (upd) begin
         btb_src[eidx] = epc;
         btb_dst[eidx] = tgt;
      end
`endif
      #1;
   endtask

   task automatic idle_inputs();
      bus.npc_op   = 3'b000;
      bus.trap_req = 1'b0;
      bus.stall    = 1'b0;
      bus.if_ready = 1'b1;
`ifdef PC_GEN_BTB_EN
      bus.btb_inv  = 1'b0;
`endif
   endtask

   task automatic test_reset();
      model_reset();
      idle_inputs();
      bus.ex_pc = 32'h0; bus.imm = 32'h0; bus.aluout = 32'h0; bus.trap_vec = 32'h0;
      bus.trap_req = 1'b1;
      bus.npc_op   = 3'b010;
      rst = 1'b1;
      #12;
      checks++;
      if (bus.pc !== RST_PC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, RST_PC); end
      checks++;
      if (bus.pc_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.pc_valid); end
      checks++;
      if (bus.flush !== 1'b0 || bus.misalign !== 1'b0 || bus.pred_taken !== 1'b0) begin
         failures++; $display("FAIL reset_flags got=%b%b%b exp=000", bus.flush, bus.misalign, bus.pred_taken);
      end
      idle_inputs();
      rst = 1'b0;
      #1;
      checks++;
      if (bus.pc_valid !== 1'b0) begin failures++; $display("FAIL boot_valid got=%b exp=0", bus.pc_valid); end
      tick();
      checks++;
      if (bus.pc_valid !== 1'b1 || bus.pc !== 32'h100) begin
         failures++; $display("FAIL boot_first got=%b/%h exp=1/00000100", bus.pc_valid, bus.pc);
      end
      tick();
      checks++;
      if (bus.pc !== 32'h104) begin failures++; $display("FAIL seq_104 got=%h exp=00000104", bus.pc); end
      tick();
      checks++;
      if (bus.pc !== 32'h108) begin failures++; $display("FAIL seq_108 got=%h exp=00000108", bus.pc); end
   endtask

   task automatic test_stall();
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (bus.flush !== 1'b0) begin failures++; $display("FAIL stall_flush got=%b exp=0", bus.flush); end
         tick();
         checks++;
         if (bus.pc !== 32'h108) begin failures++; $display("FAIL stall_hold got=%h exp=00000108", bus.pc); end
      end
      bus.stall = 1'b0;
      tick();
      checks++;
      if (bus.pc !== 32'h10C) begin failures++; $display("FAIL stall_release got=%h exp=0000010c", bus.pc); end
   endtask

   task automatic test_branch_under_stall();
      bus.npc_op = 3'b001; bus.ex_pc = 32'h104; bus.imm = 32'h20; bus.stall = 1'b1;
      #1;
      checks++;
      if (bus.flush !== 1'b1 || bus.misalign !== 1'b0) begin
         failures++; $display("FAIL branch_flags got=%b%b exp=10", bus.flush, bus.misalign);
      end
      tick();
      checks++;
      if (bus.pc !== 32'h124) begin failures++; $display("FAIL branch_pc got=%h exp=00000124", bus.pc); end
      idle_inputs();
   endtask

   task automatic test_jalr_pending();
      bus.npc_op = 3'b100; bus.aluout = 32'h203; bus.if_ready = 1'b0;
      #1;
      checks++;
      if (bus.flush !== 1'b1 || bus.misalign !== 1'b1) begin
         failures++; $display("FAIL jalr_flags got=%b%b exp=11", bus.flush, bus.misalign);
      end
      tick();
      checks++;
      if (bus.pc !== 32'h124) begin failures++; $display("FAIL pend_hold1 got=%h exp=00000124", bus.pc); end
      bus.npc_op = 3'b000;
      #1;
      checks++;
      if (bus.flush !== 1'b0) begin failures++; $display("FAIL pend_flush got=%b exp=0", bus.flush); end
      tick();
      checks++;
      if (bus.pc !== 32'h124) begin failures++; $display("FAIL pend_hold2 got=%h exp=00000124", bus.pc); end
      bus.if_ready = 1'b1;
      tick();
      checks++;
      if (bus.pc !== 32'h202) begin failures++; $display("FAIL pend_release got=%h exp=00000202", bus.pc); end
   endtask

   task automatic test_trap_priority();
      bus.trap_req = 1'b1; bus.trap_vec = 32'h800;
      bus.npc_op = 3'b010; bus.ex_pc = 32'h104; bus.imm = 32'h20;
      #1;
      checks++;
      if (bus.flush !== 1'b1) begin failures++; $display("FAIL trap_flush got=%b exp=1", bus.flush); end
      tick();
      checks++;
      if (bus.pc !== 32'h800) begin failures++; $display("FAIL trap_pc got=%h exp=00000800", bus.pc); end
      idle_inputs();
   endtask

   task automatic test_wrap_and_bad_op();
      bus.npc_op = 3'b010; bus.ex_pc = 32'hFFFF_FF00; bus.imm = 32'hFC;
      tick();
      checks++;
      if (bus.pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_tgt got=%h exp=fffffffc", bus.pc); end
      bus.npc_op = 3'b000;
      tick();
      checks++;
      if (bus.pc !== 32'h0) begin failures++; $display("FAIL wrap_zero got=%h exp=00000000", bus.pc); end
      bus.npc_op = 3'b111; bus.ex_pc = 32'h40; bus.imm = 32'h40;
      #1;
      checks++;
      if (bus.flush !== 1'b0) begin failures++; $display("FAIL badop_flush got=%b exp=0", bus.flush); end
      tick();
      checks++;
      if (bus.pc !== 32'h4) begin failures++; $display("FAIL badop_pc got=%h exp=00000004", bus.pc); end
      idle_inputs();
   endtask

`ifdef PC_GEN_BTB_EN
   task automatic test_btb();
      bus.npc_op = 3'b010; bus.ex_pc = 32'h110; bus.imm = 32'h1F0;
      tick();
      checks++;
      if (bus.pc !== 32'h300) begin failures++; $display("FAIL btb_train got=%h exp=00000300", bus.pc); end
      bus.ex_pc = 32'h0; bus.imm = 32'h108;
      tick();
      bus.npc_op = 3'b000;
      tick();
      tick();
      #1;
      checks++;
      if (bus.pc !== 32'h110 || bus.pred_taken !== 1'b1) begin
         failures++; $display("FAIL btb_hit got=%h/%b exp=00000110/1", bus.pc, bus.pred_taken);
      end
      tick();
      checks++;
      if (bus.pc !== 32'h300) begin failures++; $display("FAIL btb_target got=%h exp=00000300", bus.pc); end
      bus.btb_inv = 1'b1; bus.ex_pc = 32'h110;
      tick();
      bus.btb_inv = 1'b0;
      bus.npc_op = 3'b010; bus.ex_pc = 32'h0; bus.imm = 32'h10C;
      tick();
      bus.npc_op = 3'b000;
      tick();
      #1;
      checks++;
      if (bus.pc !== 32'h110 || bus.pred_taken !== 1'b0) begin
         failures++; $display("FAIL btb_inv_miss got=%h/%b exp=00000110/0", bus.pc, bus.pred_taken);
      end
      tick();
      checks++;
      if (bus.pc !== 32'h114) begin failures++; $display("FAIL btb_inv_seq got=%h exp=00000114", bus.pc); end
   endtask
`endif

   task automatic test_reset_in_pend();
      bus.npc_op = 3'b010; bus.ex_pc = 32'h0; bus.imm = 32'h500; bus.if_ready = 1'b0;
      tick();
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (bus.pc !== RST_PC || bus.pc_valid !== 1'b0 || bus.flush !== 1'b0) begin
         failures++; $display("FAIL pend_reset got=%h/%b/%b exp=00000100/0/0", bus.pc, bus.pc_valid, bus.flush);
      end
      idle_inputs();
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (bus.pc_valid !== 1'b0) begin failures++; $display("FAIL pend_reset_boot got=%b exp=0", bus.pc_valid); end
      tick();
      checks++;
      if (bus.pc !== 32'h100) begin failures++; $display("FAIL pend_lost1 got=%h exp=00000100", bus.pc); end
      tick();
      checks++;
      if (bus.pc !== 32'h104) begin failures++; $display("FAIL pend_lost2 got=%h exp=00000104", bus.pc); end
   endtask

   task automatic test_random();
      int r;
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 15));
         case (r)
            9, 10:   bus.npc_op = 3'b001;
            11:      bus.npc_op = 3'b010;
            12:      bus.npc_op = 3'b100;
            13:      bus.npc_op = 3'($urandom_range(5, 7));
            default: bus.npc_op = 3'b000;
         endcase
         bus.ex_pc    = ($urandom_range(0, 3) == 0) ? m_pc : 32'($urandom_range(0, 127)) << 2;
         bus.imm      = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'($urandom_range(0, 63)) << 2;
         bus.aluout   = 32'($urandom_range(0, 1023));
         bus.trap_req = ($urandom_range(0, 19) == 0);
         bus.trap_vec = 32'($urandom_range(0, 255)) << 2;
         bus.if_ready = ($urandom_range(0, 3) != 0);
         bus.stall    = ($urandom_range(0, 4) == 0);
`ifdef PC_GEN_BTB_EN
         bus.btb_inv  = ($urandom_range(0, 15) == 0);
`endif
         #1;
         checks++;
         if (bus.flush !== m_redir()) begin
            failures++; $display("FAIL rnd_flush cyc=%0d got=%b exp=%b", i, bus.flush, m_redir());
         end
         checks++;
         if (bus.misalign !== (m_redir() && (m_target() & 32'h3) != 0)) begin
            failures++; $display("FAIL rnd_misalign cyc=%0d got=%b", i, bus.misalign);
         end
         checks++;
         if (bus.pred_taken !== m_pred()) begin
            failures++; $display("FAIL rnd_pred cyc=%0d got=%b exp=%b", i, bus.pred_taken, m_pred());
         end
         tick();
         checks++;
         if (bus.pc !== m_pc || bus.pc_valid !== 1'b1) begin
            failures++; $display("FAIL rnd_pc cyc=%0d got=%h/%b exp=%h/1", i, bus.pc, bus.pc_valid, m_pc);
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_stall();
      test_branch_under_stall();
      test_jalr_pending();
      test_trap_priority();
      test_wrap_and_bad_op();
`ifdef PC_GEN_BTB_EN
      test_btb();
`endif
      test_reset_in_pend();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
